// File: rtl/toy_bus_pkg.sv
// -----------------------------------------------------------------------------
// toy_bus_pkg
// Shared definitions for the toy bus network.
//   - Width localparams for the default ToyBusReq layout.
//   - toy_bus_req_t : packed request struct (addr, strb, data, opcode,
//                     src_id, tgt_id), MSB first in that order.
//   - Opcode constants TOY_BUS_OP_RD / TOY_BUS_OP_WR.
// No ports (package).
// -----------------------------------------------------------------------------
package toy_bus_pkg;

    localparam int TOY_BUS_ADDR_W = 32;
    localparam int TOY_BUS_DATA_W = 32;
    localparam int TOY_BUS_STRB_W = TOY_BUS_DATA_W / 8;
    localparam int TOY_BUS_ID_W   = 4;

    localparam logic TOY_BUS_OP_RD = 1'b0;
    localparam logic TOY_BUS_OP_WR = 1'b1;

    typedef struct packed {
        logic [TOY_BUS_ADDR_W-1:0] addr;
        logic [TOY_BUS_STRB_W-1:0] strb;
        logic [TOY_BUS_DATA_W-1:0] data;
        logic                      opcode;
        logic [TOY_BUS_ID_W-1:0]   src_id;
        logic [TOY_BUS_ID_W-1:0]   tgt_id;
    } toy_bus_req_t;

endpackage

// File: rtl/toy_bus_skid2.sv
// -----------------------------------------------------------------------------
// toy_bus_skid2
// Generic 2-entry FIFO with valid/ready handshakes on both sides.
// The input ready is registered so it never depends combinationally on the
// downstream ready; two entries are enough to keep 1 transfer/cycle.
// Storage is not reset; only pointers, count and ready are.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_vld/in_rdy/in_data write side (push on in_vld && in_rdy)
//   out_vld/out_rdy/out_data read side (pop on out_vld && out_rdy)
// -----------------------------------------------------------------------------
module toy_bus_skid2
    import toy_bus_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [PAYLOAD_W-1:0] out_data
);

    logic [PAYLOAD_W-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic [1:0]           count_next;
    logic                 push;
    logic                 pop;

    assign push     = in_vld && in_rdy;
    assign out_vld  = (count != 2'd0);
    assign pop      = out_vld && out_rdy;
    assign out_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            in_rdy <= 1'b1;
        end else begin
            count  <= count_next;
            // Ready looks one cycle ahead so a pop at count==2 reopens the
            // input on the following cycle.
            in_rdy <= (count_next < 2'd2);
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/toy_bus_req_dec_pipe.sv
// -----------------------------------------------------------------------------
// toy_bus_req_dec_pipe
// Registered request decoder: one ToyBusReq stream in, N_OUT channels out.
// Requests are buffered in a 2-entry skid FIFO; the head entry is routed to
// the lowest channel whose RTE_MASK row contains its tgt_id. Unmapped heads
// are dropped one cycle after becoming valid and reported on the err_* port.
// Optional feature (macro TOY_BUS_DEC_PERF_EN): per-channel 16-bit
// saturating handshake counters on perf_cnt, cleared by rst_n or perf_clr.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_vld/in_rdy, in_*           request input (in_rdy registered)
//   out_vld[N_OUT]/out_rdy[N_OUT] per-channel handshake (one-hot or zero)
//   out_*                         head payload, shared by all channels
//   err_vld/err_tgt_id            drop pulse and tgt_id of last drop
//   err_sticky/err_clr            sticky drop flag and its clear
//   perf_clr/perf_cnt             (TOY_BUS_DEC_PERF_EN only)
// -----------------------------------------------------------------------------
module toy_bus_req_dec_pipe
    import toy_bus_pkg::*;
#(
    parameter int N_OUT  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8,
    parameter int ID_W   = 4,
    parameter logic [N_OUT*(2**ID_W)-1:0] RTE_MASK = 32'h00B8_0004
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [STRB_W-1:0] in_strb,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_opcode,
    input  logic [ID_W-1:0]   in_src_id,
    input  logic [ID_W-1:0]   in_tgt_id,
    output logic [N_OUT-1:0]  out_vld,
    input  logic [N_OUT-1:0]  out_rdy,
    output logic [ADDR_W-1:0] out_addr,
    output logic [STRB_W-1:0] out_strb,
    output logic [DATA_W-1:0] out_data,
    output logic              out_opcode,
    output logic [ID_W-1:0]   out_src_id,
    output logic [ID_W-1:0]   out_tgt_id,
    output logic              err_vld,
    output logic [ID_W-1:0]   err_tgt_id,
    output logic              err_sticky,
    input  logic              err_clr
`ifdef TOY_BUS_DEC_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [N_OUT*16-1:0] perf_cnt
`endif
);

    localparam int NT        = 2**ID_W;
    localparam int PAYLOAD_W = ADDR_W + STRB_W + DATA_W + 1 + 2*ID_W;

    logic [PAYLOAD_W-1:0] fifo_in;
    logic [PAYLOAD_W-1:0] head;
    logic [PAYLOAD_W-1:0] head_shown;
    logic                 head_vld;
    logic                 head_pop;
    logic [ID_W-1:0]      head_tgt;
    logic [N_OUT-1:0]     hit;
    logic                 mapped;
    logic                 drop;

    assign fifo_in = {in_addr, in_strb, in_data, in_opcode, in_src_id, in_tgt_id};

    toy_bus_skid2 #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (fifo_in),
        .out_vld  (head_vld),
        .out_rdy  (head_pop),
        .out_data (head)
    );

    // Payload reads as zero while the FIFO is empty, so the (unreset)
    // storage never leaks onto the outputs after reset.
    assign head_shown = head_vld ? head : '0;
    assign {out_addr, out_strb, out_data, out_opcode, out_src_id, out_tgt_id} = head_shown;
    assign head_tgt = head[ID_W-1:0];

    always_comb begin
        hit = '0;
        for (int o = 0; o < N_OUT; o++) begin
            logic [NT-1:0] row;
            row    = RTE_MASK[o*NT +: NT];
            hit[o] = row[head_tgt];
        end
    end

    assign mapped = |hit;
    assign drop   = head_vld && !mapped;

    // hit & -hit isolates the lowest set bit: overlapping masks resolve to
    // the lowest-numbered channel.
    assign out_vld = (head_vld && mapped) ? (hit & (~hit + N_OUT'(1))) : '0;

    // Only the selected channel's ready matters, since out_vld is one-hot.
    assign head_pop = (|(out_vld & out_rdy)) || drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_vld    <= 1'b0;
            err_tgt_id <= '0;
            err_sticky <= 1'b0;
        end else begin
            err_vld <= drop;
            if (drop) begin
                err_tgt_id <= head_tgt;
            end
            // A drop in the same cycle as err_clr keeps the flag set.
            if (drop) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

`ifdef TOY_BUS_DEC_PERF_EN
    logic [N_OUT-1:0] hs;
    assign hs = out_vld & out_rdy;

    for (genvar o = 0; o < N_OUT; o++) begin : g_perf
        always_ff @(posedge clk) begin
            if (!rst_n || perf_clr) begin
                perf_cnt[o*16 +: 16] <= 16'h0000;
            end else if (hs[o] && (perf_cnt[o*16 +: 16] != 16'hFFFF)) begin
                perf_cnt[o*16 +: 16] <= perf_cnt[o*16 +: 16] + 16'h0001;
            end
        end
    end
`else
    // Handshake counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_toy_bus_req_dec_pipe.sv
module tb_toy_bus_req_dec_pipe;
    import toy_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [31:0] in_addr = '0;
    logic [3:0]  in_strb = '0;
    logic [31:0] in_data = '0;
    logic        in_opcode = 1'b0;
    logic [3:0]  in_src_id = '0;
    logic [3:0]  in_tgt_id = '0;
    logic [1:0]  out_vld;
    logic [1:0]  out_rdy = 2'b00;
    logic [31:0] out_addr;
    logic [3:0]  out_strb;
    logic [31:0] out_data;
    logic        out_opcode;
    logic [3:0]  out_src_id;
    logic [3:0]  out_tgt_id;
    logic        err_vld;
    logic [3:0]  err_tgt_id;
    logic        err_sticky;
    logic        err_clr = 1'b0;
`ifdef TOY_BUS_DEC_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] perf_cnt;
`endif

    typedef struct {
        int          chan;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic        op;
        logic [3:0]  src;
        logic [3:0]  tgt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   hs_first = 0;
    int   hs_last = 0;
    int   stalls = 0;

    toy_bus_req_dec_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_addr    (in_addr),
        .in_strb    (in_strb),
        .in_data    (in_data),
        .in_opcode  (in_opcode),
        .in_src_id  (in_src_id),
        .in_tgt_id  (in_tgt_id),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_addr   (out_addr),
        .out_strb   (out_strb),
        .out_data   (out_data),
        .out_opcode (out_opcode),
        .out_src_id (out_src_id),
        .out_tgt_id (out_tgt_id),
        .err_vld    (err_vld),
        .err_tgt_id (err_tgt_id),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
`ifdef TOY_BUS_DEC_PERF_EN
        ,
        .perf_clr   (perf_clr),
        .perf_cnt   (perf_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Default routing table: tgt 2 -> ch0; tgt 3,4,5,7 -> ch1; others drop.
    function automatic int exp_chan(input logic [3:0] tgt);
        case (tgt)
            4'd2:                   return 0;
            4'd3, 4'd4, 4'd5, 4'd7: return 1;
            default:                return -1;
        endcase
    endfunction

    // Scoreboard: every handshake is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int o = 0; o < 2; o++) begin
                if (out_vld[o] && out_rdy[o]) begin
                    n_vec++;
                    hs_cnt++;
                    if (hs_cnt == 1) hs_first = cyc;
                    hs_last = cyc;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_hs: ch%0d addr=%h, required no output", o, out_addr);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (o != e.chan || out_addr !== e.addr || out_data !== e.data ||
                            out_strb !== e.strb || out_opcode !== e.op ||
                            out_src_id !== e.src || out_tgt_id !== e.tgt) begin
                            n_err++;
                            $display("FAIL hs_payload: got ch%0d addr=%h data=%h strb=%h op=%b src=%h tgt=%h, required ch%0d addr=%h data=%h strb=%h op=%b src=%h tgt=%h",
                                     o, out_addr, out_data, out_strb, out_opcode, out_src_id, out_tgt_id,
                                     e.chan, e.addr, e.data, e.strb, e.op, e.src, e.tgt);
                        end
                    end
                end
            end
        end
    end

    // Drive one request and wait for it to be accepted; returns just after
    // the accepting edge with in_vld still high.
    task automatic send(input logic [3:0] tgt, input logic [31:0] addr, input logic [31:0] data);
        bit done = 0;
        in_vld    = 1'b1;
        in_tgt_id = tgt;
        in_addr   = addr;
        in_data   = data;
        in_opcode = data[0] ? TOY_BUS_OP_WR : TOY_BUS_OP_RD;
        in_strb   = data[7:4];
        in_src_id = addr[3:0] ^ 4'h5;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_rdy) begin
                @(posedge clk);
                #1;
                done = 1;
                if (exp_chan(tgt) >= 0) begin
                    exp_t e;
                    e.chan = exp_chan(tgt);
                    e.addr = addr;
                    e.data = data;
                    e.strb = data[7:4];
                    e.op   = data[0];
                    e.src  = addr[3:0] ^ 4'h5;
                    e.tgt  = tgt;
                    sb.push_back(e);
                end
            end else begin
                stalls++;
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: tgt=%0d not accepted within 50 cycles, required acceptance", tgt);
        end
    endtask

    task automatic idle(input int n);
        in_vld = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (in_rdy !== 1'b1 || out_vld !== 2'b00 || err_vld !== 1'b0 ||
            err_sticky !== 1'b0 || err_tgt_id !== 4'd0 || out_addr !== 32'd0 || out_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: in_rdy=%b out_vld=%b err_vld=%b sticky=%b err_tgt=%h addr=%h data=%h, required 1 00 0 0 0 0 0",
                     in_rdy, out_vld, err_vld, err_sticky, err_tgt_id, out_addr, out_data);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_route();
        out_rdy = 2'b11;
        send(4'd2, 32'h1000_0040, 32'hDEAD_BEEF);
        n_vec++;
        if (out_vld !== 2'b01 || out_addr !== 32'h1000_0040 || out_data !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL route_tgt2: out_vld=%b addr=%h data=%h, required 01 10000040 deadbeef", out_vld, out_addr, out_data);
        end
        send(4'd4, 32'h2000_0080, 32'h1234_5671);
        n_vec++;
        if (out_vld !== 2'b10 || out_addr !== 32'h2000_0080) begin
            n_err++;
            $display("FAIL route_tgt4: out_vld=%b addr=%h, required 10 20000080", out_vld, out_addr);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        out_rdy = 2'b11;
        hs_cnt  = 0;
        stalls  = 0;
        for (int i = 0; i < 8; i++) begin
            send((i % 2) ? 4'd7 : 4'd2, 32'h3000_0000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i * 17));
        end
        idle(3);
        n_vec++;
        if (hs_cnt !== 8 || (hs_last - hs_first) !== 7 || stalls !== 0) begin
            n_err++;
            $display("FAIL b2b_throughput: hs=%0d span=%0d stalls=%0d, required 8 7 0", hs_cnt, hs_last - hs_first, stalls);
        end
    endtask

    task automatic test_backpressure();
        out_rdy = 2'b01;
        send(4'd3, 32'h4000_0000, 32'h0000_0011);
        send(4'd3, 32'h4000_0004, 32'h0000_0022);
        in_tgt_id = 4'd3;
        in_addr   = 32'h4000_0008;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (in_rdy !== 1'b0 || out_vld !== 2'b10 || out_addr !== 32'h4000_0000) begin
                n_err++;
                $display("FAIL bp_stall: in_rdy=%b out_vld=%b addr=%h, required 0 10 40000000", in_rdy, out_vld, out_addr);
            end
        end
        @(posedge clk);
        #1;
        out_rdy = 2'b11;
        send(4'd3, 32'h4000_0008, 32'h0000_0033);
        idle(4);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain: %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_unmapped();
        out_rdy = 2'b11;
        send(4'd9, 32'h5000_0000, 32'h0000_0099);
        in_vld = 1'b0;
        n_vec++;
        if (out_vld !== 2'b00 || err_vld !== 1'b0) begin
            n_err++;
            $display("FAIL unmapped_head: out_vld=%b err_vld=%b, required 00 0", out_vld, err_vld);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (err_vld !== 1'b1 || err_tgt_id !== 4'd9 || err_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL unmapped_err: err_vld=%b tgt=%0d sticky=%b, required 1 9 1", err_vld, err_tgt_id, err_sticky);
        end
        send(4'd2, 32'h5000_0010, 32'h0000_00AB);
        in_vld = 1'b0;
        n_vec++;
        if (err_vld !== 1'b0 || err_sticky !== 1'b1 || out_vld !== 2'b01) begin
            n_err++;
            $display("FAIL after_drop: err_vld=%b sticky=%b out_vld=%b, required 0 1 01", err_vld, err_sticky, out_vld);
        end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        n_vec++;
        if (err_sticky !== 1'b0 || err_tgt_id !== 4'd9) begin
            n_err++;
            $display("FAIL err_clr: sticky=%b tgt=%0d, required 0 9", err_sticky, err_tgt_id);
        end
        // Clear held through a new drop: the drop must win.
        err_clr = 1'b1;
        send(4'd10, 32'h5000_0020, 32'h0000_0000);
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        n_vec++;
        if (err_vld !== 1'b1 || err_sticky !== 1'b1 || err_tgt_id !== 4'd10) begin
            n_err++;
            $display("FAIL set_wins: err_vld=%b sticky=%b tgt=%0d, required 1 1 10", err_vld, err_sticky, err_tgt_id);
        end
        // Consecutive drops pulse err_vld on consecutive cycles.
        send(4'd9, 32'h5000_0030, 32'h0000_0000);
        send(4'd12, 32'h5000_0034, 32'h0000_0000);
        in_vld = 1'b0;
        n_vec++;
        if (err_vld !== 1'b1 || err_tgt_id !== 4'd9) begin
            n_err++;
            $display("FAIL b2b_drop_first: err_vld=%b tgt=%0d, required 1 9", err_vld, err_tgt_id);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (err_vld !== 1'b1 || err_tgt_id !== 4'd12) begin
            n_err++;
            $display("FAIL b2b_drop_second: err_vld=%b tgt=%0d, required 1 12", err_vld, err_tgt_id);
        end
        idle(2);
        n_vec++;
        if (err_vld !== 1'b0) begin
            n_err++;
            $display("FAIL err_pulse_end: err_vld=%b, required 0", err_vld);
        end
    endtask

    task automatic test_reset_mid();
        out_rdy = 2'b00;
        send(4'd2, 32'h6000_0000, 32'h0000_0061);
        send(4'd4, 32'h6000_0004, 32'h0000_0062);
        in_vld = 1'b0;
        n_vec++;
        if (in_rdy !== 1'b0 || out_vld !== 2'b01) begin
            n_err++;
            $display("FAIL full_before_rst: in_rdy=%b out_vld=%b, required 0 01", in_rdy, out_vld);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        n_vec++;
        if (out_vld !== 2'b00 || in_rdy !== 1'b1 || out_addr !== 32'd0) begin
            n_err++;
            $display("FAIL after_rst: out_vld=%b in_rdy=%b addr=%h, required 00 1 0", out_vld, in_rdy, out_addr);
        end
        out_rdy = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if (out_vld !== 2'b00) begin
                n_err++;
                $display("FAIL stale_out: out_vld=%b, required 00", out_vld);
            end
        end
        @(posedge clk);
        #1;
    endtask

`ifdef TOY_BUS_DEC_PERF_EN
    task automatic test_perf();
        out_rdy  = 2'b11;
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(4'd3, 32'h7000_0000 + 32'(i), 32'h0000_0070);
        end
        idle(3);
        n_vec++;
        if (perf_cnt[31:16] !== 16'd5 || perf_cnt[15:0] !== 16'd0) begin
            n_err++;
            $display("FAIL perf_count: ch1=%0d ch0=%0d, required 5 0", perf_cnt[31:16], perf_cnt[15:0]);
        end
        for (int i = 0; i < 65540; i++) begin
            send(4'd3, 32'h7100_0000, 32'h0000_0071);
        end
        idle(3);
        n_vec++;
        if (perf_cnt[31:16] !== 16'hFFFF) begin
            n_err++;
            $display("FAIL perf_saturate: ch1=%h, required ffff", perf_cnt[31:16]);
        end
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        n_vec++;
        if (perf_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL perf_clr: cnt=%h, required 0", perf_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_route();
        test_back_to_back();
        test_backpressure();
        test_unmapped();
        test_reset_mid();
`ifdef TOY_BUS_DEC_PERF_EN
        test_perf();
`endif
        idle(2);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_empty: %0d expected requests never delivered, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
